// File: rtl/imm_gen_pipe_pkg.sv
// Shared constants for the immediate generator pipeline stage.
// Opcode patterns are matched against instr[31:21] at their natural widths.
package imm_gen_pipe_pkg;

    localparam int WORD      = 64;
    localparam int INSTR_LEN = 32;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_D    = 3'd2,
        FMT_CB   = 3'd3,
        FMT_B    = 3'd4,
        FMT_IW   = 3'd5
    } fmt_e;

    localparam logic [9:0] OP_ADDI  = 10'h244;
    localparam logic [9:0] OP_ADDIS = 10'h2C4;
    localparam logic [9:0] OP_ANDI  = 10'h248;
    localparam logic [9:0] OP_ANDIS = 10'h3C8;
    localparam logic [9:0] OP_EORI  = 10'h348;
    localparam logic [9:0] OP_ORRI  = 10'h2C8;
    localparam logic [9:0] OP_SUBI  = 10'h344;
    localparam logic [9:0] OP_SUBIS = 10'h3C4;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;

    localparam logic [7:0] OP_CBZ  = 8'hB4;
    localparam logic [7:0] OP_CBNZ = 8'hB5;

    localparam logic [5:0] OP_B  = 6'h05;
    localparam logic [5:0] OP_BL = 6'h25;

    localparam logic [8:0] OP_MOVZ = 9'h1A5;
    localparam logic [8:0] OP_MOVK = 9'h1E5;

endpackage

// File: rtl/imm_gen_if.sv
// Valid/ready bundle between IF-ID and the immediate generator.
// The slave side is the generator, the master side is its environment.
interface imm_gen_if #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32,
    parameter int TAG_W     = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_LEN-1:0] in_instr;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD-1:0]      out_imm;
    logic [2:0]           out_fmt;
    logic                 out_wide_keep;
    logic                 out_illegal;
    logic [TAG_W-1:0]     out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt,
        input  out_wide_keep, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt,
        output out_wide_keep, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_fmt_decode.sv
// Combinational format classifier and immediate extender.
module imm_fmt_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int WORD         = imm_gen_pipe_pkg::WORD,
    parameter int INSTR_LEN    = imm_gen_pipe_pkg::INSTR_LEN,
    parameter int BRANCH_SHIFT = 1,
    parameter int I_ZERO_EXT   = 0
) (
    input  logic [INSTR_LEN-1:0] instr,
    output logic [WORD-1:0]      imm,
    output fmt_e                 fmt,
    output logic                 wide_keep,
    output logic                 illegal
);
    logic [10:0]     op;
    logic            is_i, is_d, is_cb, is_b, is_iw;
    logic            i_sign;
    logic [WORD-1:0] cb_ext, b_ext, iw_ext;
    logic            unused_rd;

    assign op        = instr[31:21];
    assign unused_rd = ^instr[4:0];
    assign i_sign    = instr[21] & (I_ZERO_EXT == 0);

    assign is_i  = op[10:1] inside {OP_ADDI, OP_ADDIS, OP_ANDI, OP_ANDIS,
                                    OP_EORI, OP_ORRI, OP_SUBI, OP_SUBIS};
    assign is_d  = op inside {OP_LDUR, OP_STUR};
    assign is_cb = op[10:3] inside {OP_CBZ, OP_CBNZ};
    assign is_b  = op[10:5] inside {OP_B, OP_BL};
    assign is_iw = op[10:2] inside {OP_MOVZ, OP_MOVK};

    assign cb_ext = {{(WORD-19){instr[23]}}, instr[23:5]};
    assign b_ext  = {{(WORD-26){instr[25]}}, instr[25:0]};
    assign iw_ext = {{(WORD-16){1'b0}}, instr[20:5]};

    always_comb begin
        imm       = '0;
        fmt       = FMT_NONE;
        wide_keep = 1'b0;
        illegal   = 1'b0;
        unique case (1'b1)
            is_i: begin
                fmt = FMT_I;
                imm = {{(WORD-12){i_sign}}, instr[21:10]};
            end
            is_d: begin
                fmt = FMT_D;
                imm = {{(WORD-9){instr[20]}}, instr[20:12]};
            end
            is_cb: begin
                fmt = FMT_CB;
                imm = (BRANCH_SHIFT != 0) ? (cb_ext << 2) : cb_ext;
            end
            is_b: begin
                fmt = FMT_B;
                imm = (BRANCH_SHIFT != 0) ? (b_ext << 2) : b_ext;
            end
            is_iw: begin
                fmt       = FMT_IW;
                imm       = iw_ext << {instr[22:21], 4'b0000};
                wide_keep = (op[10:2] == OP_MOVK);
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode plus a 2-entry skid buffer.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int WORD         = imm_gen_pipe_pkg::WORD,
    parameter int INSTR_LEN    = imm_gen_pipe_pkg::INSTR_LEN,
    parameter int TAG_W        = 64,
    parameter int BRANCH_SHIFT = 1,
    parameter int I_ZERO_EXT   = 0
) (
    input logic  clk,
    input logic  rst_n,
    input logic  flush,
    imm_gen_if.slave bus
);
    logic [WORD-1:0]  dec_imm;
    fmt_e             dec_fmt;
    logic             dec_keep, dec_ill;

    imm_fmt_decode #(
        .WORD(WORD), .INSTR_LEN(INSTR_LEN),
        .BRANCH_SHIFT(BRANCH_SHIFT), .I_ZERO_EXT(I_ZERO_EXT)
    ) u_dec (
        .instr(bus.in_instr), .imm(dec_imm), .fmt(dec_fmt),
        .wide_keep(dec_keep), .illegal(dec_ill)
    );

    logic             main_v, skid_v, rdy;
    logic [WORD-1:0]  main_imm, skid_imm;
    fmt_e             main_fmt, skid_fmt;
    logic             main_keep, skid_keep;
    logic             main_ill, skid_ill;
    logic [TAG_W-1:0] main_tag, skid_tag;
    logic             acc, main_free;

    assign acc       = bus.in_valid && rdy;
    assign main_free = !main_v || bus.out_ready;

    // Main is refilled from skid first so beats never overtake each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_v    <= 1'b0;
            skid_v    <= 1'b0;
            rdy       <= 1'b1;
            main_imm  <= '0;
            main_fmt  <= FMT_NONE;
            main_keep <= 1'b0;
            main_ill  <= 1'b0;
            main_tag  <= '0;
            skid_imm  <= '0;
            skid_fmt  <= FMT_NONE;
            skid_keep <= 1'b0;
            skid_ill  <= 1'b0;
            skid_tag  <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy    <= 1'b1;
        end else if (main_free) begin
            rdy <= 1'b1;
            if (skid_v) begin
                main_v    <= 1'b1;
                skid_v    <= 1'b0;
                main_imm  <= skid_imm;
                main_fmt  <= skid_fmt;
                main_keep <= skid_keep;
                main_ill  <= skid_ill;
                main_tag  <= skid_tag;
            end else begin
                main_v <= acc;
                if (acc) begin
                    main_imm  <= dec_imm;
                    main_fmt  <= dec_fmt;
                    main_keep <= dec_keep;
                    main_ill  <= dec_ill;
                    main_tag  <= bus.in_tag;
                end
            end
        end else if (acc) begin
            skid_v    <= 1'b1;
            rdy       <= 1'b0;
            skid_imm  <= dec_imm;
            skid_fmt  <= dec_fmt;
            skid_keep <= dec_keep;
            skid_ill  <= dec_ill;
            skid_tag  <= bus.in_tag;
        end else begin
            rdy <= !skid_v;
        end
    end

    assign bus.in_ready      = rdy;
    assign bus.out_valid     = main_v;
    assign bus.out_imm       = main_imm;
    assign bus.out_fmt       = main_fmt;
    assign bus.out_wide_keep = main_keep;
    assign bus.out_illegal   = main_ill;
    assign bus.out_tag       = main_tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: vector table, scoreboard, stall/flush/reset cases.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [63:0] imm_alt;
        logic [2:0]  fmt;
        logic        keep;
        logic        ill;
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [63:0] tag;
    } exp_t;

    localparam int NV = 15;

    logic clk = 1'b0;
    logic rst_n, flush;
    always #5 clk = ~clk;

    imm_gen_if bus ();
    imm_gen_if bus_z ();

    imm_gen_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
    );

    // Second instance: zero-extended ALU immediates, word branch offsets.
    imm_gen_pipe #(.I_ZERO_EXT(1), .BRANCH_SHIFT(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_z)
    );

    assign bus_z.in_valid  = bus.in_valid;
    assign bus_z.in_instr  = bus.in_instr;
    assign bus_z.in_tag    = bus.in_tag;
    assign bus_z.out_ready = bus.out_ready;

    vec_t        tbl [NV];
    exp_t        sb [$];
    exp_t        cur;
    int          n_pass = 0;
    int          n_total = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] snap_imm, snap_tag;
    logic        last_acc;
    int          steps;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic drive(input int idx, input logic [63:0] tag);
        cur.v        = tbl[idx];
        cur.tag      = tag;
        bus.in_valid = 1'b1;
        bus.in_instr = tbl[idx].instr;
        bus.in_tag   = tag;
    endtask

    // One clock: score outputs, record accepted beats, advance past the edge.
    task automatic step();
        exp_t e;
        if (stall_prev) begin
            check("stable_imm", bus.out_imm, snap_imm);
            check("stable_tag", bus.out_tag, snap_tag);
        end
        if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("tag", bus.out_tag, e.tag);
                check("imm", bus.out_imm, e.v.imm);
                check("fmt", 64'(bus.out_fmt), 64'(e.v.fmt));
                check("wide_keep", 64'(bus.out_wide_keep), 64'(e.v.keep));
                check("illegal", 64'(bus.out_illegal), 64'(e.v.ill));
                check("imm_alt", bus_z.out_imm, e.v.imm_alt);
            end
        end
        last_acc = bus.in_valid && bus.in_ready;
        if (flush) sb.delete();
        else if (last_acc) sb.push_back(cur);
        stall_prev = bus.out_valid && !bus.out_ready && !flush;
        snap_imm   = bus.out_imm;
        snap_tag   = bus.out_tag;
        steps++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [63:0] tag);
        bit done = 0;
        drive(idx, tag);
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            done = last_acc;
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) step();
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h913FFC41, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0FFF, 3'd1, 1'b0, 1'b0};
        tbl[1]  = '{32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 3'd4, 1'b0, 1'b0};
        tbl[2]  = '{32'hB4000020, 64'h0000_0000_0000_0004, 64'h0000_0000_0000_0001, 3'd3, 1'b0, 1'b0};
        tbl[3]  = '{32'hD2C24680, 64'h0000_1234_0000_0000, 64'h0000_1234_0000_0000, 3'd5, 1'b0, 1'b0};
        tbl[4]  = '{32'hF2C24680, 64'h0000_1234_0000_0000, 64'h0000_1234_0000_0000, 3'd5, 1'b1, 1'b0};
        tbl[5]  = '{32'hF8500000, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FF00, 3'd2, 1'b0, 1'b0};
        tbl[6]  = '{32'h00000000, 64'h0, 64'h0, 3'd0, 1'b0, 1'b1};
        tbl[7]  = '{32'hD11FFC00, 64'h0000_0000_0000_07FF, 64'h0000_0000_0000_07FF, 3'd1, 1'b0, 1'b0};
        tbl[8]  = '{32'hB2200000, 64'hFFFF_FFFF_FFFF_F800, 64'h0000_0000_0000_0800, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{32'h94000010, 64'h0000_0000_0000_0040, 64'h0000_0000_0000_0010, 3'd4, 1'b0, 1'b0};
        tbl[10] = '{32'hB5FFFFE0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3, 1'b0, 1'b0};
        tbl[11] = '{32'hF80FF000, 64'h0000_0000_0000_00FF, 64'h0000_0000_0000_00FF, 3'd2, 1'b0, 1'b0};
        tbl[12] = '{32'hF2FFFFE0, 64'hFFFF_0000_0000_0000, 64'hFFFF_0000_0000_0000, 3'd5, 1'b1, 1'b0};
        tbl[13] = '{32'hFFFFFFFF, 64'h0, 64'h0, 3'd0, 1'b0, 1'b1};
        tbl[14] = '{32'hD2800020, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 3'd5, 1'b0, 1'b0};

        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        steps         = 0;

        #12;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_imm", bus.out_imm, 64'd0);
        check("rst_fmt", 64'(bus.out_fmt), 64'd0);
        check("rst_keep", 64'(bus.out_wide_keep), 64'd0);
        check("rst_illegal", 64'(bus.out_illegal), 64'd0);
        check("rst_tag", bus.out_tag, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat: presented the cycle after acceptance.
        bus.out_ready = 1'b1;
        send(0, 64'h100);
        check("latency_valid", 64'(bus.out_valid), 64'd1);
        drain();

        // Back-to-back table stream, one beat per cycle.
        steps = 0;
        for (int i = 0; i < NV; i++) send(i, 64'h1000 + 64'(i));
        check("throughput_cycles", 64'(steps), 64'(NV));
        drain();

        // Five beats with out_ready low for two cycles mid-stream.
        begin
            int k = 0;
            for (int cyc = 0; cyc < 30 && k < 5; cyc++) begin
                drive(k, 64'h2000 + 64'(k));
                bus.out_ready = !(cyc == 2 || cyc == 3);
                if (cyc == 2) check("bp_ready_before", 64'(bus.in_ready), 64'd1);
                if (cyc == 3) check("bp_ready_low", 64'(bus.in_ready), 64'd0);
                step();
                if (last_acc) k++;
            end
            check("bp_all_sent", 64'(k), 64'd5);
        end
        drain();

        // Flush with main and skid full and a third beat offered.
        bus.out_ready = 1'b0;
        send(3, 64'h3000);
        send(4, 64'h3001);
        check("fl_skid_full", 64'(bus.in_ready), 64'd0);
        drive(5, 64'h3002);
        flush = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_out_valid", 64'(bus.out_valid), 64'd0);
        check("fl_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        repeat (3) step();
        check("fl_no_beat", 64'(bus.out_valid), 64'd0);

        // Flush wins over a beat accepted in the same cycle.
        bus.out_ready = 1'b0;
        send(7, 64'h3100);
        drive(8, 64'h3101);
        flush = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl2_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        repeat (2) step();

        // Asynchronous reset mid-stream clears outputs without a clock edge.
        send(9, 64'h4000);
        send(12, 64'h4001);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_imm", bus.out_imm, 64'd0);
        check("arst_tag", bus.out_tag, 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, 64'h5000);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the decode-stage immediate extender. Classifies each instruction's format, extracts and extends its immediate to WORD bits, and optionally pre-scales branch offsets.
- Adds MOVZ/MOVK wide-immediate support, an illegal flag and a valid/ready handshake through a 2-entry skid buffer.
- Sits between fetch/IF-ID and the register-read stage of the pipelined core.

Parameters:
- WORD, 64: output immediate width; must be ≥ 64 for wide-immediate (hw up to 3).
- INSTR_LEN, 32: instruction width.
- TAG_W, 64: sideband tag width (PC), carried unchanged.
- BRANCH_SHIFT, 1: 1 = B/CB offsets shifted left by 2 (byte offset); 0 = word offset.
- I_ZERO_EXT, 0: 1 = ALU immediates zero-extended; 0 = sign-extended from bit 21.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  input instruction valid.
- in_ready  out  1  block can accept; registered.
- in_instr  in  INSTR_LEN  instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  WORD  extended immediate.
- out_fmt  out  3  format code: 0 NONE, 1 I, 2 D, 3 CB, 4 B, 5 IW.
- out_wide_keep  out  1  1 for MOVK (merge), 0 otherwise.
- out_illegal  out  1  opcode matched no known format.
- out_tag  out  TAG_W  tag of the output instruction.

Behaviour:
- Reset (rst_n low, asynchronous): both buffer entries invalid. out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_wide_keep=0, out_illegal=0, out_tag=0.
- Handshakes: transfer on in_valid&&in_ready and on out_valid&&out_ready. Latency 1 cycle (accepted in cycle N, presented in N+1). Throughput 1 per cycle.
- Classification, on in_instr[31:21]:
  - I: ADDI/ADDIS/ANDI/ANDIS/EORI/ORRI/SUBI/SUBIS (10-bit opcodes).
  - D: LDUR/STUR (11-bit).
  - CB: CBZ/CBNZ (8-bit).
  - B: B/BL (6-bit).
  - IW: MOVZ/MOVK (9-bit).
  - Anything else: fmt=NONE, illegal=1, imm=0.
- Extension:
  - I: imm12=[21:10]; zero- or sign-extended per I_ZERO_EXT.
  - D: sign-extend [20:12].
  - CB: sign-extend [23:5], then <<2 if BRANCH_SHIFT.
  - B: sign-extend [25:0], then <<2 if BRANCH_SHIFT.
  - IW: zero-extend [20:5], then << (16*hw), hw=[22:21].
  - All arithmetic is done at WORD width; shifted-out bits are discarded.
- Buffer: main entry drives the outputs; the skid entry catches the beat when out_ready drops while in_ready was high.
  - in_ready next = !(skid valid after update).
  - Drain: when main is consumed and skid is valid, skid moves to main.
  - Fill order is preserved: no reordering, no drop, no duplication.
- Simultaneous accept and consume with main valid and skid empty: main is replaced by the new beat; out_valid stays 1.
- Output stability: while out_valid && !out_ready, all out_* hold stable.
- Flush: both entries invalidated next cycle; any beat accepted in the same cycle is discarded. After flush, out_valid=0 and in_ready=1. Flush has priority over every other event.
- Reset asserted mid-transfer: immediate clear; no partial state survives.

Decomposition:
- Shared constants header: opcode patterns (add ADDIS, SUBIS, CBNZ, BL, MOVZ, MOVK to the existing set), fmt code constants FMT_NONE..FMT_IW, WORD and INSTR_LEN.
- Sub-module imm_fmt_decode: purely combinational instr → {fmt, imm, wide_keep, illegal}, parametrised like the parent.
- imm_gen_pipe holds only the skid buffer and control.

Test Plan:
- ADDI, in_instr=0x913FFC41, I_ZERO_EXT=0 → one cycle later out_imm=0xFFFFFFFFFFFFFFFF, fmt=1. With I_ZERO_EXT=1 → out_imm=0x0000000000000FFF.
- B, 0x17FFFFFF, BRANCH_SHIFT=1 → out_imm=0xFFFFFFFFFFFFFFFC, fmt=4. CBZ, 0xB4000020 → out_imm=0x4, fmt=3.
- Wide immediate and D-format:
  - MOVZ, 0xD2C24680 → out_imm=0x0000123400000000, fmt=5, wide_keep=0.
  - MOVK with the same fields, 0xF2C24680 → same imm, wide_keep=1.
  - LDUR, 0xF8500000 → out_imm=0xFFFFFFFFFFFFFF00, fmt=2.
- Illegal: 0x00000000 → fmt=0, illegal=1, out_imm=0.
- Backpressure: stream 5 beats with out_ready low for 2 cycles mid-stream → in_ready drops 1 cycle after the skid fills; all 5 emerge in order, none lost or duplicated; outputs stable while stalled.
- Flush asserted with both entries full plus in_valid high → next cycle out_valid=0, in_ready=1, none of the 3 beats appears. Async rst_n pulse mid-stream → outputs zero immediately.
